// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM types, default framing bytes and divisor helper
// for the UART frame receiver. UART_FRAME_XSUM_EN adds the P_XSUM state.
package uart_frame_pkg;

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } byte_fsm_t;

`ifdef UART_FRAME_XSUM_EN
   typedef enum logic [2:0] {
      P_IDLE,
      P_CMD,
      P_DATA,
      P_XSUM,
      P_ETX
   } parse_fsm_t;
`else
   typedef enum logic [2:0] {
      P_IDLE,
      P_CMD,
      P_DATA,
      P_ETX
   } parse_fsm_t;
`endif

   localparam logic [7:0] STX_DEFAULT = 8'h02;
   localparam logic [7:0] ETX_DEFAULT = 8'h03;

   // Oversample divisor, floored, never below 1.
   function automatic int calc_div(input int clk_hz, input int baud);
      int d;
      d = clk_hz / (baud * 16);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 2-flop rx synchroniser, 16x tick generator and 8N1 byte FSM.
// Ports: clk, rst (async active-low), rx in; data, byte_done, frame_bad out.
module uart_byte_rx
   import uart_frame_pkg::*;
#(
   parameter int DIV = 27
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_done,
   output logic       frame_bad
);

   localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

   logic          rx_s1_q;
   logic          rx_s2_q;
   logic          rx_s3_q;
   logic [CW-1:0] div_q, div_d;
   byte_fsm_t     st_q, st_d;
   logic [3:0]    tck_q, tck_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d;
   logic          done_q, done_d;
   logic          bad_q, bad_d;
   logic          tick;
   logic          fall;

   assign tick = (div_q == DIV_LAST);
   // rx_s3_q is the previous synchronised sample, used only for edge detect.
   assign fall = rx_s3_q & ~rx_s2_q;

   always_comb begin
      st_d   = st_q;
      div_d  = tick ? '0 : div_q + 1'b1;
      tck_d  = tck_q;
      bit_d  = bit_q;
      sh_d   = sh_q;
      done_d = 1'b0;
      bad_d  = 1'b0;
      case (st_q)
         B_IDLE: begin
            if (fall) begin
               st_d  = B_START;
               div_d = '0;
               tck_d = '0;
            end
         end
         B_START: begin
            if (tick) begin
               tck_d = tck_q + 4'd1;
               // Mid start bit: a high line means the edge was a glitch.
               if (tck_q == 4'd7) begin
                  tck_d = '0;
                  bit_d = '0;
                  st_d  = rx_s2_q ? B_IDLE : B_DATA;
               end
            end
         end
         B_DATA: begin
            if (tick) begin
               tck_d = tck_q + 4'd1;
               if (tck_q == 4'd15) begin
                  sh_d  = {rx_s2_q, sh_q[7:1]};
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) begin
                     st_d = B_STOP;
                  end
               end
            end
         end
         B_STOP: begin
            if (tick) begin
               tck_d = tck_q + 4'd1;
               if (tck_q == 4'd15) begin
                  done_d = rx_s2_q;
                  bad_d  = ~rx_s2_q;
                  st_d   = B_IDLE;
               end
            end
         end
         default: st_d = B_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
         div_q   <= '0;
         st_q    <= B_IDLE;
         tck_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         done_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
         div_q   <= div_d;
         st_q    <= st_d;
         tck_q   <= tck_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         done_q  <= done_d;
         bad_q   <= bad_d;
      end
   end

   assign data      = sh_q;
   assign byte_done = done_q;
   assign frame_bad = bad_q;

endmodule

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: STX/CMD/payload/ETX frame parser over a 16x UART byte
// receiver, with atomic commit, inter-byte timeout and a registered byte
// select. Ports: clk, rst (async active-low), rx, sel in; cmd, payload,
// byte_out, frame_valid, frame_err, busy out.
// Optional checksum byte before ETX: define UART_FRAME_XSUM_EN.
module uart_frame_rx
   import uart_frame_pkg::*;
#(
   parameter int         CLK_HZ        = 50000000,
   parameter int         BAUD          = 115200,
   parameter int         PAYLOAD_BYTES = 4,
   parameter logic [7:0] STX           = STX_DEFAULT,
   parameter logic [7:0] ETX           = ETX_DEFAULT,
   parameter int         TIMEOUT_BITS  = 20,
   localparam int        SEL_W         =
      (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       rx,
   input  logic [SEL_W-1:0]           sel,
   output logic [7:0]                 cmd,
   output logic [8*PAYLOAD_BYTES-1:0] payload,
   output logic [7:0]                 byte_out,
   output logic                       frame_valid,
   output logic                       frame_err,
   output logic                       busy
);

   localparam int               DIV      = calc_div(CLK_HZ, BAUD);
   localparam int               PW       = 8 * PAYLOAD_BYTES;
   // The timer counts clocks; TIMEOUT_BITS*16 ticks of DIV clocks each.
   localparam int               TO_CLKS  = TIMEOUT_BITS * 16 * DIV;
   localparam int               TO_W     = $clog2(TO_CLKS + 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CLKS - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(PAYLOAD_BYTES - 1);

   logic [7:0] b_data;
   logic       b_done;
   logic       b_bad;

   uart_byte_rx #(
      .DIV (DIV)
   ) u_byte (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .data      (b_data),
      .byte_done (b_done),
      .frame_bad (b_bad)
   );

   parse_fsm_t       st_q, st_d;
   logic [SEL_W-1:0] idx_q, idx_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [7:0]       cmd_sh_q, cmd_sh_d;
   logic [PW-1:0]    pay_sh_q, pay_sh_d;
   logic [7:0]       cmd_q, cmd_d;
   logic [PW-1:0]    pay_q, pay_d;
   logic             fv_q, fv_d;
   logic             fe_q, fe_d;
   logic [7:0]       bo_q, bo_d;
   logic             busy_w;
   logic             timeout;
`ifdef UART_FRAME_XSUM_EN
   logic [7:0]       xs_q, xs_d;
`endif

   assign busy_w  = (st_q != P_IDLE);
   assign timeout = busy_w && (to_q == TO_LAST);

   always_comb begin
      st_d     = st_q;
      idx_d    = idx_q;
      cmd_sh_d = cmd_sh_q;
      pay_sh_d = pay_sh_q;
      cmd_d    = cmd_q;
      pay_d    = pay_q;
      fv_d     = 1'b0;
      fe_d     = 1'b0;
`ifdef UART_FRAME_XSUM_EN
      xs_d     = xs_q;
`endif
      // Timer reloads on every byte, so byte_done beats a same-cycle expiry.
      if (!busy_w || b_done) begin
         to_d = '0;
      end else if (!timeout) begin
         to_d = to_q + 1'b1;
      end else begin
         to_d = to_q;
      end

      if (b_done) begin
         case (st_q)
            P_IDLE: begin
               if (b_data == STX) begin
                  st_d = P_CMD;
               end
            end
            P_CMD: begin
               cmd_sh_d = b_data;
               idx_d    = '0;
               st_d     = P_DATA;
`ifdef UART_FRAME_XSUM_EN
               xs_d     = b_data;
`endif
            end
            P_DATA: begin
               pay_sh_d[int'(idx_q)*8 +: 8] = b_data;
`ifdef UART_FRAME_XSUM_EN
               xs_d = xs_q ^ b_data;
`endif
               if (idx_q == IDX_LAST) begin
`ifdef UART_FRAME_XSUM_EN
                  st_d = P_XSUM;
`else
                  st_d = P_ETX;
`endif
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
`ifdef UART_FRAME_XSUM_EN
            P_XSUM: begin
               if (b_data == xs_q) begin
                  st_d = P_ETX;
               end else begin
                  fe_d = 1'b1;
                  st_d = P_IDLE;
               end
            end
`endif
            P_ETX: begin
               if (b_data == ETX) begin
                  cmd_d = cmd_sh_q;
                  pay_d = pay_sh_q;
                  fv_d  = 1'b1;
               end else begin
                  fe_d  = 1'b1;
               end
               st_d = P_IDLE;
            end
            default: st_d = P_IDLE;
         endcase
      end else if (busy_w && (b_bad || timeout)) begin
         fe_d = 1'b1;
         st_d = P_IDLE;
      end
   end

   // Out-of-range selects fall through to zero.
   always_comb begin
      bo_d = '0;
      for (int i = 0; i < PAYLOAD_BYTES; i++) begin
         if (int'(sel) == i) begin
            bo_d = pay_q[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q     <= P_IDLE;
         idx_q    <= '0;
         to_q     <= '0;
         cmd_sh_q <= '0;
         pay_sh_q <= '0;
         cmd_q    <= '0;
         pay_q    <= '0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
         bo_q     <= '0;
`ifdef UART_FRAME_XSUM_EN
         xs_q     <= '0;
`endif
      end else begin
         st_q     <= st_d;
         idx_q    <= idx_d;
         to_q     <= to_d;
         cmd_sh_q <= cmd_sh_d;
         pay_sh_q <= pay_sh_d;
         cmd_q    <= cmd_d;
         pay_q    <= pay_d;
         fv_q     <= fv_d;
         fe_q     <= fe_d;
         bo_q     <= bo_d;
`ifdef UART_FRAME_XSUM_EN
         xs_q     <= xs_d;
`endif
      end
   end

   assign cmd         = cmd_q;
   assign payload     = pay_q;
   assign byte_out    = bo_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign busy        = busy_w;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: scenario-driven bench for uart_frame_rx with a frame
// scoreboard; runs at a fast baud (DIV=3) to keep the run short.
module tb_uart_frame_rx;

   localparam int CLK_HZ   = 50000000;
   localparam int BAUD     = 1000000;
   localparam int DIV      = 3;
   localparam int BIT_CLKS = 16 * DIV;
   localparam int TO_CLKS  = 20 * 16 * DIV;

   typedef logic [39:0] frm_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [1:0]  sel;
   logic [7:0]  cmd;
   logic [31:0] payload;
   logic [7:0]  byte_out;
   logic        frame_valid;
   logic        frame_err;
   logic        busy;

   int   n_chk = 0;
   int   n_fail = 0;
   int   fv_cnt = 0;
   int   fe_cnt = 0;
   frm_t exp_q[$];
   frm_t got_q[$];

   always #10 clk = ~clk;

   uart_frame_rx #(
      .CLK_HZ        (CLK_HZ),
      .BAUD          (BAUD),
      .PAYLOAD_BYTES (4),
      .STX           (8'h02),
      .ETX           (8'h03),
      .TIMEOUT_BITS  (20)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx),
      .sel         (sel),
      .cmd         (cmd),
      .payload     (payload),
      .byte_out    (byte_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         fv_cnt++;
         got_q.push_back({cmd, payload});
      end
      if (frame_err === 1'b1) begin
         fe_cnt++;
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (BIT_CLKS) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT_CLKS) @(negedge clk);
      end
      rx = stop;
      repeat (BIT_CLKS) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [31:0] p);
      logic [7:0] xs;
      xs = c;
      send_byte(8'h02, 1'b1);
      send_byte(c, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_byte(p[i*8 +: 8], 1'b1);
         xs = xs ^ p[i*8 +: 8];
      end
`ifdef UART_FRAME_XSUM_EN
      send_byte(xs, 1'b1);
`endif
      send_byte(8'h03, 1'b1);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      rx  = 1'b1;
      sel = 2'd0;
      repeat (5) @(negedge clk);
      n_chk++;
      if (cmd !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_cmd got %h want 00", cmd);
      end
      n_chk++;
      if (payload !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_payload got %h want 0", payload);
      end
      n_chk++;
      if (byte_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_byte_out got %h want 00", byte_out);
      end
      n_chk++;
      if ({frame_valid, frame_err, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got %b want 000",
                  {frame_valid, frame_err, busy});
      end
      rst = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_good_frame();
      int   fv0, fe0;
      frm_t g, e;
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      exp_q.push_back({8'hFF, 32'h32160804});
      send_frame(8'hFF, 32'h32160804);
      n_chk++;
      if (fv_cnt - fv0 !== 1) begin
         n_fail++;
         $display("FAIL good_fv_count got %0d want 1", fv_cnt - fv0);
      end
      n_chk++;
      if (fe_cnt - fe0 !== 0) begin
         n_fail++;
         $display("FAIL good_fe_count got %0d want 0", fe_cnt - fe0);
      end
      n_chk++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL good_sb got no frame want %h", {8'hFF, 32'h32160804});
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            n_fail++;
            $display("FAIL good_sb got %h want %h", g, e);
         end
      end
      n_chk++;
      if (byte_out !== 8'h04) begin
         n_fail++;
         $display("FAIL good_sel0 got %h want 04", byte_out);
      end
      sel = 2'd3;
      #1;
      n_chk++;
      if (byte_out !== 8'h04) begin
         n_fail++;
         $display("FAIL good_sel_reg got %h want 04", byte_out);
      end
      @(negedge clk);
      n_chk++;
      if (byte_out !== 8'h32) begin
         n_fail++;
         $display("FAIL good_sel3 got %h want 32", byte_out);
      end
   endtask

   task automatic test_framing_error();
      int   fv0, fe0;
      frm_t g, e;
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_byte(8'h02, 1'b1);
      send_byte(8'h7F, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h11, 1'b0);
      repeat (8) @(negedge clk);
      n_chk++;
      if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
         n_fail++;
         $display("FAIL ferr_pulses got fe=%0d fv=%0d want fe=1 fv=0",
                  fe_cnt - fe0, fv_cnt - fv0);
      end
      n_chk++;
      if ({cmd, payload} !== {8'hFF, 32'h32160804}) begin
         n_fail++;
         $display("FAIL ferr_hold got %h want ff32160804", {cmd, payload});
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ferr_busy got %b want 0", busy);
      end
      exp_q.push_back({8'hA5, 32'h04030201});
      send_frame(8'hA5, 32'h04030201);
      n_chk++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL ferr_next_sb got no frame want a504030201");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            n_fail++;
            $display("FAIL ferr_next_sb got %h want %h", g, e);
         end
      end
   endtask

   task automatic test_bad_term();
      int   fv0, fe0;
      frm_t g, e;
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      send_byte(8'h02, 1'b1);
      send_byte(8'h7F, 1'b1);
      for (int i = 0; i < 4; i++) begin
         send_byte(8'h00, 1'b1);
      end
      send_byte(8'h05, 1'b1);
      repeat (4) @(negedge clk);
      n_chk++;
      if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
         n_fail++;
         $display("FAIL badterm_pulses got fe=%0d fv=%0d want fe=1 fv=0",
                  fe_cnt - fe0, fv_cnt - fv0);
      end
      n_chk++;
      if (cmd !== 8'hA5) begin
         n_fail++;
         $display("FAIL badterm_hold got %h want a5", cmd);
      end
      fv0 = fv_cnt;
      send_byte(8'h55, 1'b1);
      exp_q.push_back({8'h7E, 32'h0});
      send_frame(8'h7E, 32'h0);
      n_chk++;
      if (fv_cnt - fv0 !== 1) begin
         n_fail++;
         $display("FAIL badterm_next_fv got %0d want 1", fv_cnt - fv0);
      end
      n_chk++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL badterm_next_sb got no frame want 7e00000000");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            n_fail++;
            $display("FAIL badterm_next_sb got %h want %h", g, e);
         end
      end
   endtask

   task automatic test_glitch_timeout();
      int fv0, fe0;
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      @(negedge clk);
      rx = 1'b0;
      repeat (4 * DIV) @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || fe_cnt != fe0 || fv_cnt != fv0) begin
         n_fail++;
         $display("FAIL glitch got busy=%b fe=%0d fv=%0d want 0 0 0",
                  busy, fe_cnt - fe0, fv_cnt - fv0);
      end
      send_byte(8'h02, 1'b1);
      send_byte(8'hFE, 1'b1);
      send_byte(8'h0A, 1'b1);
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_busy got %b want 1", busy);
      end
      repeat (TO_CLKS - 110) @(negedge clk);
      n_chk++;
      if (busy !== 1'b1 || fe_cnt != fe0) begin
         n_fail++;
         $display("FAIL tmo_early got busy=%b fe=%0d want 1 0",
                  busy, fe_cnt - fe0);
      end
      repeat (250) @(negedge clk);
      n_chk++;
      if (busy !== 1'b0 || fe_cnt - fe0 !== 1) begin
         n_fail++;
         $display("FAIL tmo_abort got busy=%b fe=%0d want 0 1",
                  busy, fe_cnt - fe0);
      end
   endtask

   task automatic test_async_reset();
      frm_t g, e;
      send_byte(8'h02, 1'b1);
      send_byte(8'h11, 1'b1);
      @(negedge clk);
      rx = 1'b0;
      repeat (30) @(negedge clk);
      #3;
      rst = 1'b0;
      #1;
      n_chk++;
      if ({cmd, payload, byte_out} !== 48'h0) begin
         n_fail++;
         $display("FAIL arst_data got %h want 0", {cmd, payload, byte_out});
      end
      n_chk++;
      if ({frame_valid, frame_err, busy} !== 3'b000) begin
         n_fail++;
         $display("FAIL arst_flags got %b want 000",
                  {frame_valid, frame_err, busy});
      end
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      exp_q.push_back({8'hC3, 32'hDEADBEEF});
      send_frame(8'hC3, 32'hDEADBEEF);
      n_chk++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL arst_next_sb got no frame want c3deadbeef");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            n_fail++;
            $display("FAIL arst_next_sb got %h want %h", g, e);
         end
      end
      n_chk++;
      if (byte_out !== 8'hDE) begin
         n_fail++;
         $display("FAIL arst_sel3 got %h want de", byte_out);
      end
   endtask

`ifdef UART_FRAME_XSUM_EN
   task automatic test_xsum();
      int          fv0, fe0;
      frm_t        g, e;
      logic [7:0]  seq[8];
      seq = '{8'h02, 8'hFE, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFE, 8'h03};
      exp_q.push_back({8'hFE, 32'h0D0C0B0A});
      for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b1);
      repeat (4) @(negedge clk);
      n_chk++;
      if (got_q.size() == 0 || exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL xsum_good_sb got no frame want fe0d0c0b0a");
      end else begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         if (g !== e) begin
            n_fail++;
            $display("FAIL xsum_good_sb got %h want %h", g, e);
         end
      end
      fv0 = fv_cnt;
      fe0 = fe_cnt;
      seq[6] = 8'h00;
      for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b1);
      repeat (4) @(negedge clk);
      n_chk++;
      if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0) begin
         n_fail++;
         $display("FAIL xsum_bad got fe=%0d fv=%0d want fe=1 fv=0",
                  fe_cnt - fe0, fv_cnt - fv0);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_good_frame();
      test_framing_error();
      test_bad_term();
      test_glitch_timeout();
      test_async_reset();
`ifdef UART_FRAME_XSUM_EN
      test_xsum();
`endif
      n_chk++;
      if (exp_q.size() != 0 || got_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got exp=%0d got=%0d want 0 0",
                  exp_q.size(), got_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
